// File: rtl/adder_req_scheduler.sv
// adder_req_scheduler: two-requester arbiter that sequences wide additions through one shared DATA_W adder slice
//   clk_i/rst_ni            clock, async active-low reset
//   reqN_valid/ready/a/b/carry  request ports (round-robin when both valid, accepted only in IDLE)
//   rsp_valid/ready/sum/carry/id registered response
//   add_a/b/carry_o, add_sum/carry_i  shared external adder slice, driven only in CALC
//   busy_o                  high in CALC or RESP
//   ADDER_REQ_SCHEDULER_STATS_EN adds done0_cnt_o/done1_cnt_o completion counters
module adder_req_scheduler #(
  parameter int DATA_W = 8,
  parameter int NUM_SLICES = 2,
  localparam int OP_W = DATA_W * NUM_SLICES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_a_i,
  input  logic [OP_W-1:0]   req0_b_i,
  input  logic              req0_carry_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_a_i,
  input  logic [OP_W-1:0]   req1_b_i,
  input  logic              req1_carry_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [OP_W-1:0]   rsp_sum_o,
  output logic              rsp_carry_o,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] add_a_o,
  output logic [DATA_W-1:0] add_b_o,
  output logic              add_carry_o,
  input  logic [DATA_W-1:0] add_sum_i,
  input  logic              add_carry_i,
`ifdef ADDER_REQ_SCHEDULER_STATS_EN
  output logic [15:0]       done0_cnt_o,
  output logic [15:0]       done1_cnt_o,
`endif
  output logic              busy_o
);
  localparam int KW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state_q, state_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, id_q, id_d, rr_q, rr_d;
  logic [KW-1:0] k_q, k_d;
  logic gnt1, calc;
  // rr_q set means requester 1 is preferred when both are valid
  assign gnt1 = req1_valid_i & (~req0_valid_i | rr_q);
  assign calc = state_q == CALC;
  assign req0_ready_o = (state_q == IDLE) & req0_valid_i & ~gnt1;
  assign req1_ready_o = (state_q == IDLE) & gnt1;
  assign add_a_o = calc ? a_q[k_q*DATA_W +: DATA_W] : '0;
  assign add_b_o = calc ? b_q[k_q*DATA_W +: DATA_W] : '0;
  assign add_carry_o = calc & carry_q;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_sum_o = sum_q;
  assign rsp_carry_o = carry_q;
  assign rsp_id_o = id_q;
  assign busy_o = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    id_d = id_q;
    rr_d = rr_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (req0_valid_i | req1_valid_i) begin
        a_d = gnt1 ? req1_a_i : req0_a_i;
        b_d = gnt1 ? req1_b_i : req0_b_i;
        carry_d = gnt1 ? req1_carry_i : req0_carry_i;
        id_d = gnt1;
        rr_d = ~gnt1;
        k_d = '0;
        state_d = CALC;
      end
      CALC: begin
        sum_d[k_q*DATA_W +: DATA_W] = add_sum_i;
        carry_d = add_carry_i;
        k_d = k_q + 1'b1;
        state_d = k_q == KW'(NUM_SLICES - 1) ? RESP : CALC;
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      id_q <= 1'b0;
      rr_q <= 1'b0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      id_q <= id_d;
      rr_q <= rr_d;
      k_q <= k_d;
    end
  end
`ifdef ADDER_REQ_SCHEDULER_STATS_EN
  logic [15:0] done0_q, done0_d, done1_q, done1_d;
  logic done;
  assign done = rsp_valid_o & rsp_ready_i;
  assign done0_d = done0_q + 16'(done & ~id_q);
  assign done1_d = done1_q + 16'(done & id_q);
  assign done0_cnt_o = done0_q;
  assign done1_cnt_o = done1_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done0_q <= '0;
      done1_q <= '0;
    end else begin
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end
`endif
endmodule

// File: tb/tb_adder_req_scheduler.sv
// tb_adder_req_scheduler: directed scoreboard bench for adder_req_scheduler with an ideal adder slice model
module tb_adder_req_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, req0_c = 0, req1_c = 0, rsp_ready = 0;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_carry, rsp_id, add_carry_o, add_carry_i, busy;
  logic [15:0] rsp_sum;
  logic [7:0] add_a, add_b, add_sum;
`ifdef ADDER_REQ_SCHEDULER_STATS_EN
  logic [15:0] done0_cnt, done1_cnt;
`endif
  typedef struct packed {logic id; logic c; logic [15:0] s;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, exp0 = 0, exp1 = 0, n;

  always #5 clk = ~clk;
  assign {add_carry_i, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_carry_o};

  adder_req_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_carry_i(req0_c),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_carry_i(req1_c),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_sum_o(rsp_sum), .rsp_carry_o(rsp_carry), .rsp_id_o(rsp_id),
    .add_a_o(add_a), .add_b_o(add_b), .add_carry_o(add_carry_o), .add_sum_i(add_sum), .add_carry_i(add_carry_i),
`ifdef ADDER_REQ_SCHEDULER_STATS_EN
    .done0_cnt_o(done0_cnt), .done1_cnt_o(done1_cnt),
`endif
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    sb.push_back({id, r[16], r[15:0]});
  endtask

  task automatic wait_rsp(output int cyc);
    step();
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    chk("rsp_valid", rsp_valid, 1);
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("rsp_sum", rsp_sum, e.s);
      chk("rsp_carry", rsp_carry, e.c);
      chk("rsp_id", rsp_id, e.id);
      if (e.id) exp1++; else exp0++;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_add"}, {add_a, add_b, add_carry_o}, 0);
    chk({tag, "_rsp"}, {rsp_sum, rsp_carry, rsp_id}, 0);
  endtask

  initial begin
    #12;
    chk_idle_outputs("reset");
    rst_n = 1;
    step();
    // single request from requester 0
    rsp_ready = 1;
    req0_valid = 1; req0_a = 16'hCBF7; req0_b = 16'h9932; req0_c = 0;
    #1;
    chk("t1_ready", {req0_ready, req1_ready}, 2'b10);
    push(0, req0_a, req0_b, req0_c);
    step();
    req0_valid = 0;
    chk("t1_slice0", {add_a, add_b, add_carry_o}, {8'hF7, 8'h32, 1'b0});
    chk("t1_busy", busy, 1);
    chk("t1_ready_calc", {req0_ready, req1_ready}, 0);
    step();
    chk("t1_slice1", {add_a, add_b, add_carry_o}, {8'hCB, 8'h99, 1'b1});
    chk("t1_not_yet", rsp_valid, 0);
    step();
    check_rsp();
    step();
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_busy", busy, 0);
    chk("t1_add_idle", {add_a, add_b, add_carry_o}, 0);
    // async reset mid-CALC, with carry register set by slice 0
    req1_valid = 1; req1_a = 16'h00FF; req1_b = 16'h0001; req1_c = 1;
    #1;
    chk("rst_pref1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 0;
    step();
    #2;
    rst_n = 0;
    #1;
    chk_idle_outputs("midrst");
    @(posedge clk);
    #3;
    rst_n = 1;
    exp0 = 0; exp1 = 0;
    step();
    // simultaneous requests after reset: requester 0 first
    req0_valid = 1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_c = 0;
    req1_valid = 1; req1_a = 16'hFFFF; req1_b = 16'h0000; req1_c = 1;
    #1;
    chk("t2_ready", {req0_ready, req1_ready}, 2'b10);
    push(0, req0_a, req0_b, req0_c);
    push(1, req1_a, req1_b, req1_c);
    step();
    req0_valid = 0;
    wait_rsp(n);
    chk("t2_lat", n, 2);
    check_rsp();
    wait_rsp(n);
    check_rsp();
    req1_valid = 0;
    // both continuously valid: strict alternation
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h1111; req0_c = 1;
    req1_valid = 1; req1_a = 16'h8000; req1_b = 16'h8000; req1_c = 0;
    for (int i = 0; i < 4; i++) push(i[0], i[0] ? req1_a : req0_a, i[0] ? req1_b : req0_b, i[0] ? req1_c : req0_c);
    for (int i = 0; i < 4; i++) begin
      wait_rsp(n);
      chk("t3_interval", n, 4);
      check_rsp();
      if (i == 3) begin
        req0_valid = 0;
        req1_valid = 0;
      end
    end
    // backpressure in RESP
    step();
    req0_valid = 1; req0_a = 16'hABCD; req0_b = 16'h1234; req0_c = 1;
    push(0, req0_a, req0_b, req0_c);
    step();
    req0_valid = 0;
    rsp_ready = 0;
    wait_rsp(n);
    chk("t4_lat", n, 2);
    check_rsp();
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_data", {rsp_sum, rsp_carry, rsp_id}, {16'hBE02, 1'b0, 1'b0});
      chk("t4_hold_ready", {req0_ready, req1_ready}, 0);
      chk("t4_hold_busy", busy, 1);
    end
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1;
    step();
    chk("t4_done_valid", rsp_valid, 0);
    chk("t4_done_busy", busy, 0);
    chk("sb_drained", sb.size(), 0);
`ifdef ADDER_REQ_SCHEDULER_STATS_EN
    chk("done0_cnt", done0_cnt, exp0);
    chk("done1_cnt", done1_cnt, exp1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
